// File: rtl/fixed_div_pkg.sv
// Shared types and helpers for the sequential signed fixed-point divider.
package fixed_div_pkg;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   // One quotient bit per cycle over the dividend pre-shifted by FRAC.
   function automatic int iter_of(input int n, input int frac);
      return n + frac;
   endfunction

   // Returned wide so callers can slice to N or ITER bits (up to 128).
   function automatic logic [127:0] sat_max(input int n);
      return (128'd1 << (n - 1)) - 128'd1;
   endfunction

   function automatic logic [127:0] sat_min_mag(input int n);
      return 128'd1 << (n - 1);
   endfunction

endpackage

// File: rtl/fixed_div_seq_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module div_restore_step #(
   parameter int N = 32
) (
   input  logic [N-1:0] rem,
   input  logic         next_bit,
   input  logic [N-1:0] divisor,
   output logic [N-1:0] rem_next,
   output logic         q_bit
);

   logic [N:0] trial;

   assign trial = {rem, next_bit};
   assign q_bit = (trial >= {1'b0, divisor});
   // When the subtract happens the true difference fits in N bits, so modular low bits suffice.
   assign rem_next = q_bit ? (trial[N-1:0] - divisor) : trial[N-1:0];

endmodule

// File: rtl/fixed_div_seq.sv
// Sequential signed fixed-point divider: radix-2 restoring, one quotient bit per cycle,
// valid/ready on both sides, saturating results with divide-by-zero and overflow flags.
module fixed_div_seq
   import fixed_div_pkg::*;
#(
   parameter int N    = 32,
   parameter int FRAC = 12
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] quotient,
   output logic         div_by_zero,
   output logic         overflow
);

   localparam int ITER = iter_of(N, FRAC);
   localparam int CW   = $clog2(ITER);
   localparam logic [CW-1:0]   LAST  = CW'(ITER - 1);
   localparam logic [127:0]    MAX_W = sat_max(N);
   localparam logic [127:0]    MIN_W = sat_min_mag(N);
   localparam logic [ITER-1:0] Q_MAX = MAX_W[ITER-1:0];
   localparam logic [ITER-1:0] Q_MIN = MIN_W[ITER-1:0];

   state_t          state;
   logic [N-1:0]    rem;
   logic [N-1:0]    divisor;
   logic [ITER-1:0] dividend;
   logic [ITER-1:0] q;
   logic [CW-1:0]   count;
   logic            sign;
   logic            sign_a;

   logic [N-1:0]    a_abs;
   logic [N-1:0]    b_abs;
   logic [N-1:0]    rem_next;
   logic            q_bit;

   // Unsigned magnitude; the most-negative value maps to 2^(N-1), which fits in N bits.
   assign a_abs = a[N-1] ? -a : a;
   assign b_abs = b[N-1] ? -b : b;

   div_restore_step #(.N(N)) u_step (
      .rem      (rem),
      .next_bit (dividend[ITER-1]),
      .divisor  (divisor),
      .rem_next (rem_next),
      .q_bit    (q_bit)
   );

   // Handshake: a transfer happens on a rising edge where valid && ready; both
   // ready and valid below are decoded from registered state only.
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         rem         <= '0;
         divisor     <= '0;
         dividend    <= '0;
         q           <= '0;
         count       <= '0;
         sign        <= 1'b0;
         sign_a      <= 1'b0;
         quotient    <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sign     <= a[N-1] ^ b[N-1];
                  sign_a   <= a[N-1];
                  divisor  <= b_abs;
                  dividend <= {a_abs, {FRAC{1'b0}}};
                  rem      <= '0;
                  q        <= '0;
                  count    <= '0;
                  state    <= (b_abs == '0) ? FIX : CALC;
               end
            end
            CALC: begin
               rem      <= rem_next;
               q        <= {q[ITER-2:0], q_bit};
               dividend <= {dividend[ITER-2:0], 1'b0};
               count    <= count + 1'b1;
               if (count == LAST) state <= FIX;
            end
            FIX: begin
               if (divisor == '0) begin
                  quotient    <= sign_a ? MIN_W[N-1:0] : MAX_W[N-1:0];
                  div_by_zero <= 1'b1;
                  overflow    <= 1'b0;
               end else if (!sign) begin
                  div_by_zero <= 1'b0;
                  overflow    <= (q > Q_MAX);
                  quotient    <= (q > Q_MAX) ? MAX_W[N-1:0] : q[N-1:0];
               end else begin
                  // Negating zero yields zero, so a zero result never carries a sign.
                  div_by_zero <= 1'b0;
                  overflow    <= (q > Q_MIN);
                  quotient    <= (q > Q_MIN) ? MIN_W[N-1:0] : -(q[N-1:0]);
               end
               state <= DONE;
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fixed_div_seq.sv
// Directed bench for fixed_div_seq at N=32, FRAC=12 with hand-computed expectations.
module tb_fixed_div_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] quotient;
   logic        div_by_zero;
   logic        overflow;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   fixed_div_seq #(.N(32), .FRAC(12)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .div_by_zero (div_by_zero),
      .overflow    (overflow)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [31:0] va, input logic [31:0] vb);
      @(negedge clk);
      check("in_ready_before_accept", 64'(in_ready), 64'd1);
      a = va;
      b = vb;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = $urandom;
      b = $urandom;
   endtask

   // Counts edges after the accept edge until out_valid rises (bounded).
   task automatic wait_result(output int cyc);
      cyc = 0;
      while (!out_valid && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic take_result();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("in_ready_after_take", 64'(in_ready), 64'd1);
      check("out_valid_after_take", 64'(out_valid), 64'd0);
   endtask

   task automatic run_op(input string tag, input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] eq, input logic edz, input logic eov, input int elat);
      int cyc;
      issue(va, vb);
      wait_result(cyc);
      check({tag, "_latency"}, 64'(cyc), 64'(elat));
      check({tag, "_quotient"}, 64'(quotient), 64'(eq));
      check({tag, "_div_by_zero"}, 64'(div_by_zero), 64'(edz));
      check({tag, "_overflow"}, 64'(overflow), 64'(eov));
      take_result();
   endtask

   initial begin
      int cyc;
      logic [31:0] held;

      #12;
      check("reset_in_ready", 64'(in_ready), 64'd1);
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_quotient", 64'(quotient), 64'd0);
      check("reset_div_by_zero", 64'(div_by_zero), 64'd0);
      check("reset_overflow", 64'(overflow), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("six_by_two",    32'h0000_6000, 32'h0000_2000, 32'h0000_3000, 1'b0, 1'b0, 45);
      run_op("m3_by_two",     32'hFFFF_D000, 32'h0000_2000, 32'hFFFF_E800, 1'b0, 1'b0, 45);
      run_op("one_by_three",  32'h0000_1000, 32'h0000_3000, 32'h0000_0555, 1'b0, 1'b0, 45);
      run_op("m6_by_m2",      32'hFFFF_A000, 32'hFFFF_E000, 32'h0000_3000, 1'b0, 1'b0, 45);
      run_op("zero_by_neg",   32'h0000_0000, 32'hFFFF_D000, 32'h0000_0000, 1'b0, 1'b0, 45);
      run_op("pos_by_zero",   32'h0000_1000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1);
      run_op("neg_by_zero",   32'hFFFF_F000, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0, 1);
      run_op("max_by_lsb",    32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 45);
      run_op("min_by_m1",     32'h8000_0000, 32'hFFFF_F000, 32'h7FFF_FFFF, 1'b0, 1'b1, 45);
      run_op("min_by_one",    32'h8000_0000, 32'h0000_1000, 32'h8000_0000, 1'b0, 1'b0, 45);
      run_op("neg_sat",       32'h8000_0000, 32'h0000_0800, 32'h8000_0000, 1'b0, 1'b1, 45);

      // Stall the result for 10 cycles while poking in_valid with other operands.
      issue(32'h0000_6000, 32'h0000_2000);
      wait_result(cyc);
      check("hold_latency", 64'(cyc), 64'd45);
      held = quotient;
      check("hold_initial_quotient", 64'(held), 64'h0000_3000);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = i[0];
         a = 32'h0000_1000;
         b = 32'h0000_3000;
         @(posedge clk);
         #1;
         check("hold_quotient_stable", 64'(quotient), 64'(held));
         check("hold_out_valid", 64'(out_valid), 64'd1);
         check("hold_in_ready_low", 64'(in_ready), 64'd0);
      end
      in_valid = 1'b0;
      take_result();
      check("hold_no_extra_result", 64'(out_valid), 64'd0);

      // Asynchronous reset in the middle of CALC.
      issue(32'h0000_6000, 32'h0000_2000);
      repeat (20) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midreset_in_ready", 64'(in_ready), 64'd1);
      check("midreset_out_valid", 64'(out_valid), 64'd0);
      check("midreset_quotient", 64'(quotient), 64'd0);
      check("midreset_div_by_zero", 64'(div_by_zero), 64'd0);
      check("midreset_overflow", 64'(overflow), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("after_reset", 32'h0000_1000, 32'h0000_3000, 32'h0000_0555, 1'b0, 1'b0, 45);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
